// File: rtl/operand_collector.sv
// -----------------------------------------------------------------------------
// operand_collector
//
// Purpose:
//   Takes one issued warp packet from the issue->opcol pipeline register,
//   fetches up to three source operands from the banked register file over a
//   single read port, then offers packet, mask and operands to execute.
//   The pipeline register is held off via stall_o while a packet is in
//   flight. A flush aimed at the held warp drops the packet, and any read
//   responses still owed by the register file are absorbed before the next
//   packet is taken.
//
// Valid/ready: a transfer happens on a rising clk edge where the producer's
//   valid and the consumer's ready are both high. Producers keep payload
//   stable while valid is high and not yet accepted. rfRdReq_o/rfRdGnt_i and
//   opcolValid_o/exReady_i follow this rule. rfRdValid_i is a one-way beat
//   with no back-pressure. Responses return in request order.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   issuedSM_i .. srcReg_i     packet from the pipeline register
//                              srcReg_i holds {valid,index} per source, src0 in the LSBs
//   issuedPacketValid_i        packet offered (consumed only in IDLE)
//   flush_i, flushWarp_i       per-warp flush request
//   stall_o                    high whenever a packet is held
//   rfRdReq_o/Warp_o/Reg_o     register file read request
//   rfRdGnt_i                  request accepted this cycle
//   rfRdValid_i, rfRdData_i    in-order read response
//   opcolValid_o, exReady_i    dispatch handshake to execute
//   opcol*_o                   latched packet fields and operands
//                              opcolOperand_o has src0 in the LSBs
//   dbg_state                  current FSM state, for observation only
// -----------------------------------------------------------------------------
module operand_collector #(
   parameter int SM_W   = 1,
   parameter int WARP_W = 5,
   parameter int REG_W  = 6,
   parameter int CORE   = 32,
   parameter int DATA_W = 32,
   parameter int PKT_W  = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SM_W-1:0]            issuedSM_i,
   input  logic [WARP_W-1:0]          issuedWarp_i,
   input  logic                       issuedPacketValid_i,
   input  logic [PKT_W-1:0]           issuedPacket_i,
   input  logic [CORE-1:0]            issuedMask_i,
   input  logic [3*(REG_W+1)-1:0]     srcReg_i,
   input  logic                       flush_i,
   input  logic [WARP_W-1:0]          flushWarp_i,
   output logic                       stall_o,
   output logic                       rfRdReq_o,
   output logic [WARP_W-1:0]          rfRdWarp_o,
   output logic [REG_W-1:0]           rfRdReg_o,
   input  logic                       rfRdGnt_i,
   input  logic                       rfRdValid_i,
   input  logic [CORE*DATA_W-1:0]     rfRdData_i,
   output logic                       opcolValid_o,
   input  logic                       exReady_i,
   output logic [SM_W-1:0]            opcolSM_o,
   output logic [WARP_W-1:0]          opcolWarp_o,
   output logic [PKT_W-1:0]           opcolPacket_o,
   output logic [CORE-1:0]            opcolMask_o,
   output logic [3*CORE*DATA_W-1:0]   opcolOperand_o,
   output logic [1:0]                 dbg_state
);

   localparam int SRC_W  = REG_W + 1;
   localparam int LINE_W = CORE * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_READ     = 2'd1,
      S_DISPATCH = 2'd2,
      S_DRAIN    = 2'd3
   } state_t;

   state_t                        state;
   logic [SM_W-1:0]               sm_q;
   logic [WARP_W-1:0]             warp_q;
   logic [PKT_W-1:0]              pkt_q;
   logic [CORE-1:0]               mask_q;
   logic [2:0]                    src_valid_q;
   logic [2:0][REG_W-1:0]         src_idx_q;
   logic [2:0][LINE_W-1:0]        operand_q;
   logic [1:0]                    num_src;
   logic [1:0]                    req_cnt;
   logic [1:0]                    rsp_cnt;

   logic [2:0]                    in_valid;
   logic [2:0][REG_W-1:0]         in_idx;
   logic                          flush_hit;
   logic [1:0]                    req_slot;
   logic [1:0]                    rsp_slot;
   logic                          gnt_take;
   logic                          rsp_take;
   logic [1:0]                    req_cnt_nxt;
   logic [1:0]                    rsp_cnt_nxt;

   // Slot number of the n-th valid source, counting from src0.
   function automatic logic [1:0] nth_valid(input logic [2:0] v, input logic [1:0] n);
      logic [1:0] seen;
      nth_valid = 2'd0;
      seen      = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (v[i]) begin
            if (seen == n) nth_valid = 2'(i);
            seen = seen + 2'd1;
         end
      end
   endfunction

   always_comb begin
      in_valid = '0;
      in_idx   = '0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = srcReg_i[k*SRC_W + REG_W];
         in_idx[k]   = srcReg_i[k*SRC_W +: REG_W];
      end
   end

   // While idle the candidate packet is the one on the input, so the flush
   // is matched against the incoming warp rather than the held one.
   assign flush_hit = flush_i &&
                      (flushWarp_i == ((state == S_IDLE) ? issuedWarp_i : warp_q));

   // req_cnt/rsp_cnt are ordinals among the valid sources; map them to slots.
   assign req_slot = nth_valid(src_valid_q, req_cnt);
   assign rsp_slot = nth_valid(src_valid_q, rsp_cnt);

   // Request fields come straight from held state, so they cannot change
   // until the grant advances req_cnt.
   assign rfRdReq_o  = (state == S_READ) && (req_cnt < num_src);
   assign rfRdWarp_o = rfRdReq_o ? warp_q : '0;
   assign rfRdReg_o  = rfRdReq_o ? src_idx_q[req_slot] : '0;

   assign gnt_take = rfRdReq_o && rfRdGnt_i;
   // A beat with nothing outstanding is a protocol error and is not counted.
   assign rsp_take = rfRdValid_i && ((state == S_READ) || (state == S_DRAIN)) &&
                     (rsp_cnt != req_cnt);

   assign req_cnt_nxt = req_cnt + {1'b0, gnt_take};
   assign rsp_cnt_nxt = rsp_cnt + {1'b0, rsp_take};

   assign stall_o        = (state != S_IDLE);
   assign opcolValid_o   = (state == S_DISPATCH) && !flush_hit;
   assign opcolSM_o      = sm_q;
   assign opcolWarp_o    = warp_q;
   assign opcolPacket_o  = pkt_q;
   assign opcolMask_o    = mask_q;
   assign opcolOperand_o = operand_q;
   assign dbg_state      = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         sm_q        <= '0;
         warp_q      <= '0;
         pkt_q       <= '0;
         mask_q      <= '0;
         src_valid_q <= '0;
         src_idx_q   <= '0;
         operand_q   <= '0;
         num_src     <= '0;
         req_cnt     <= '0;
         rsp_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issuedPacketValid_i && !flush_hit) begin
                  sm_q        <= issuedSM_i;
                  warp_q      <= issuedWarp_i;
                  pkt_q       <= issuedPacket_i;
                  mask_q      <= issuedMask_i;
                  src_valid_q <= in_valid;
                  src_idx_q   <= in_idx;
                  operand_q   <= '0;
                  num_src     <= {1'b0, in_valid[0]} + {1'b0, in_valid[1]} +
                                 {1'b0, in_valid[2]};
                  req_cnt     <= '0;
                  rsp_cnt     <= '0;
                  // Every packet passes through READ, including one with no
                  // sources, so dispatch always lands 1+numSrc cycles after
                  // the accept edge when the register file is uncontended.
                  state       <= S_READ;
               end
            end

            S_READ: begin
               req_cnt <= req_cnt_nxt;
               rsp_cnt <= rsp_cnt_nxt;
               if (rsp_take) operand_q[rsp_slot] <= rfRdData_i;
               if (flush_hit) begin
                  // Grants taken this very cycle are still owed a response.
                  state <= (req_cnt_nxt > rsp_cnt_nxt) ? S_DRAIN : S_IDLE;
               end else if (rsp_cnt_nxt == num_src) begin
                  state <= S_DISPATCH;
               end
            end

            S_DISPATCH: begin
               // Either the handshake completes or the flush drops the packet;
               // no reads are outstanding here, so both return to IDLE.
               if (flush_hit || exReady_i) state <= S_IDLE;
            end

            S_DRAIN: begin
               rsp_cnt <= rsp_cnt_nxt;
               if (rsp_cnt_nxt == req_cnt) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_collector.sv
// -----------------------------------------------------------------------------
// tb_operand_collector
//
// Directed and randomized checks of operand_collector. The register file is a
// behavioural model: a random word per (warp, reg), expanded per lane, with
// in-order responses. Expected operands are derived from the packet's source
// list and that table; expected request order from the source valid bits.
// -----------------------------------------------------------------------------
module tb_operand_collector;

   localparam int CORE   = 32;
   localparam int DATA_W = 32;
   localparam int LW     = CORE * DATA_W;

   `define CHK(tag, obs, exp) chk(tag, 128'(obs), 128'(exp))

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [0:0]        issuedSM_i;
   logic [4:0]        issuedWarp_i;
   logic              issuedPacketValid_i;
   logic [127:0]      issuedPacket_i;
   logic [31:0]       issuedMask_i;
   logic [20:0]       srcReg_i;
   logic              flush_i;
   logic [4:0]        flushWarp_i;
   logic              stall_o;
   logic              rfRdReq_o;
   logic [4:0]        rfRdWarp_o;
   logic [5:0]        rfRdReg_o;
   logic              rfRdGnt_i;
   logic              rfRdValid_i;
   logic [LW-1:0]     rfRdData_i;
   logic              opcolValid_o;
   logic              exReady_i;
   logic [0:0]        opcolSM_o;
   logic [4:0]        opcolWarp_o;
   logic [127:0]      opcolPacket_o;
   logic [31:0]       opcolMask_o;
   logic [3*LW-1:0]   opcolOperand_o;
   logic [1:0]        dbg_state;

   operand_collector dut (
      .clk                 (clk),
      .reset               (reset),
      .issuedSM_i          (issuedSM_i),
      .issuedWarp_i        (issuedWarp_i),
      .issuedPacketValid_i (issuedPacketValid_i),
      .issuedPacket_i      (issuedPacket_i),
      .issuedMask_i        (issuedMask_i),
      .srcReg_i            (srcReg_i),
      .flush_i             (flush_i),
      .flushWarp_i         (flushWarp_i),
      .stall_o             (stall_o),
      .rfRdReq_o           (rfRdReq_o),
      .rfRdWarp_o          (rfRdWarp_o),
      .rfRdReg_o           (rfRdReg_o),
      .rfRdGnt_i           (rfRdGnt_i),
      .rfRdValid_i         (rfRdValid_i),
      .rfRdData_i          (rfRdData_i),
      .opcolValid_o        (opcolValid_o),
      .exReady_i           (exReady_i),
      .opcolSM_o           (opcolSM_o),
      .opcolWarp_o         (opcolWarp_o),
      .opcolPacket_o       (opcolPacket_o),
      .opcolMask_o         (opcolMask_o),
      .opcolOperand_o      (opcolOperand_o),
      .dbg_state           (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_cnt   = 0;
   int vld_cnt  = 0;
   int acc_cyc  = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (opcolValid_o && exReady_i) hs_cnt <= hs_cnt + 1;
      if (opcolValid_o) vld_cnt <= vld_cnt + 1;
   end

   // ---------------- reference model state ----------------
   logic [31:0]  rf_mem [0:31][0:63];
   logic [0:0]   cur_sm;
   logic [4:0]   cur_warp;
   logic [127:0] cur_pkt;
   logic [31:0]  cur_mask;
   logic [2:0]   cur_v;
   logic [5:0]   cur_idx [3];
   logic [5:0]   exp_q[$];          // expected request order

   // RF responder controls and logs
   logic [LW-1:0] pend_q[$];
   logic [5:0]    gnt_log[$];
   int            gnt_cyc_log[$];
   int            gnt_block = 0;
   int            gnt_allow = -1;   // -1 means unlimited
   bit            rsp_hold  = 1'b0;
   bit            gnt_rand  = 1'b0;
   bit            rsp_rand  = 1'b0;

   function automatic logic [LW-1:0] rf_line(input logic [4:0] w, input logic [5:0] r);
      logic [LW-1:0] line;
      for (int l = 0; l < CORE; l++)
         line[l*DATA_W +: DATA_W] = rf_mem[w][r] ^ (32'(l) * 32'h9E3779B9);
      return line;
   endfunction

   function automatic logic [LW-1:0] exp_slot(input int k);
      return cur_v[k] ? rf_line(cur_warp, cur_idx[k]) : '0;
   endfunction

   // ---------------- checkers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      int bad;
      bad = 0;
      for (int l = CORE - 1; l >= 0; l--)
         if (obs[l*DATA_W +: DATA_W] !== exp[l*DATA_W +: DATA_W]) bad = l;
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: lane %0d got %08h expected %08h", tag, bad,
                obs[bad*DATA_W +: DATA_W], exp[bad*DATA_W +: DATA_W]);
      end
   endtask

   task automatic check_all_zero(input string tag);
      `CHK({tag, "_state"}, dbg_state, 2'd0);
      `CHK({tag, "_stall"}, stall_o, 1'b0);
      `CHK({tag, "_req"}, {rfRdReq_o, rfRdWarp_o, rfRdReg_o}, 12'd0);
      `CHK({tag, "_valid"}, opcolValid_o, 1'b0);
      `CHK({tag, "_fields"}, {opcolSM_o, opcolWarp_o, opcolMask_o}, 38'd0);
      `CHK({tag, "_packet"}, opcolPacket_o, 128'd0);
      for (int k = 0; k < 3; k++)
         chk_slot({tag, "_operand"}, opcolOperand_o[k*LW +: LW], '0);
   endtask

   // ---------------- driver tasks (entered and left on a negedge) ----------------
   task automatic send_packet(input logic [0:0] sm, input logic [4:0] w, input logic [2:0] v,
                              input logic [5:0] i0, input logic [5:0] i1, input logic [5:0] i2);
      cur_sm   = sm;
      cur_warp = w;
      cur_v    = v;
      cur_idx[0] = i0;
      cur_idx[1] = i1;
      cur_idx[2] = i2;
      cur_pkt  = {$urandom, $urandom, $urandom, $urandom};
      cur_mask = $urandom;
      exp_q.delete();
      for (int k = 0; k < 3; k++) if (v[k]) exp_q.push_back(cur_idx[k]);
      gnt_log.delete();
      gnt_cyc_log.delete();
      issuedSM_i          = sm;
      issuedWarp_i        = w;
      issuedPacket_i      = cur_pkt;
      issuedMask_i        = cur_mask;
      srcReg_i            = {v[2], i2, v[1], i1, v[0], i0};
      issuedPacketValid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      issuedPacketValid_i = 1'b0;
      issuedPacket_i      = {$urandom, $urandom, $urandom, $urandom};
      acc_cyc             = cyc;
   endtask

   task automatic wait_valid(output int lat);
      int i;
      i = 0;
      while (!opcolValid_o && i < 200) begin
         @(negedge clk);
         i++;
      end
      `CHK("valid_seen", opcolValid_o, 1'b1);
      lat = cyc - acc_cyc;
   endtask

   // Waits for dispatch and compares every output against the model.
   task automatic expect_dispatch(input int exp_lat);
      int lat;
      wait_valid(lat);
      if (exp_lat >= 0) `CHK("latency", lat, exp_lat);
      `CHK("sm", opcolSM_o, cur_sm);
      `CHK("warp", opcolWarp_o, cur_warp);
      `CHK("packet", opcolPacket_o, cur_pkt);
      `CHK("mask", opcolMask_o, cur_mask);
      for (int k = 0; k < 3; k++)
         chk_slot($sformatf("operand%0d", k), opcolOperand_o[k*LW +: LW], exp_slot(k));
      `CHK("gnt_count", gnt_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < gnt_log.size()) `CHK("gnt_reg", gnt_log[i], exp_q[i]);
   endtask

   task automatic handshake(input int hold);
      repeat (hold) begin
         exReady_i = 1'b0;
         @(negedge clk);
      end
      exReady_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exReady_i = 1'b0;
      `CHK("idle_after_hs", dbg_state, 2'd0);
   endtask

   // ---------------- register file model ----------------
   initial begin
      rfRdGnt_i   = 1'b0;
      rfRdValid_i = 1'b0;
      rfRdData_i  = '0;
      forever begin
         @(negedge clk);
         if (!rsp_hold && pend_q.size() > 0 && (!rsp_rand || $urandom_range(1, 0) == 1)) begin
            rfRdValid_i = 1'b1;
            rfRdData_i  = pend_q.pop_front();
         end else begin
            rfRdValid_i = 1'b0;
            rfRdData_i  = {CORE{$urandom}};
         end
         rfRdGnt_i = 1'b0;
         if (rfRdReq_o) begin
            if (gnt_block > 0) begin
               gnt_block--;
            end else if (gnt_allow != 0 && (!gnt_rand || $urandom_range(1, 0) == 1)) begin
               rfRdGnt_i = 1'b1;
               if (gnt_allow > 0) gnt_allow--;
               pend_q.push_back(rf_line(rfRdWarp_o, rfRdReg_o));
               gnt_log.push_back(rfRdReg_o);
               gnt_cyc_log.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      int hs0;
      int vld0;
      int i;
      reset               = 1'b0;
      issuedSM_i          = '0;
      issuedWarp_i        = '0;
      issuedPacketValid_i = 1'b0;
      issuedPacket_i      = '0;
      issuedMask_i        = '0;
      srcReg_i            = '0;
      flush_i             = 1'b0;
      flushWarp_i         = '0;
      exReady_i           = 1'b0;
      for (int w = 0; w < 32; w++)
         for (int r = 0; r < 64; r++)
            rf_mem[w][r] = $urandom;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Three sources r1,r2,r3 on warp 4, uncontended RF, execute already ready.
      rf_mem[4][1] = 32'hA;
      rf_mem[4][2] = 32'hB;
      rf_mem[4][3] = 32'hC;
      exReady_i = 1'b1;
      send_packet(1'b1, 5'd4, 3'b111, 6'd1, 6'd2, 6'd3);
      expect_dispatch(4);
      `CHK("gnt_cyc0", gnt_cyc_log[0], acc_cyc);
      `CHK("gnt_cyc1", gnt_cyc_log[1], acc_cyc + 1);
      `CHK("gnt_cyc2", gnt_cyc_log[2], acc_cyc + 2);
      `CHK("abc_lane0", {opcolOperand_o[2*LW +: 32], opcolOperand_o[LW +: 32], opcolOperand_o[31:0]},
           96'h0000000C_0000000B_0000000A);
      handshake(0);

      // Only src1 valid: one request, data in slot 1, others zero.
      send_packet(1'b0, 5'd11, 3'b010, 6'd20, 6'd7, 6'd33);
      expect_dispatch(2);
      handshake(0);

      // No valid sources: dispatch one cycle after accept, no request.
      send_packet(1'b1, 5'd2, 3'b000, 6'd5, 6'd6, 6'd7);
      expect_dispatch(1);
      handshake(0);

      // Grant withheld 5 cycles, then execute stalls 3 cycles.
      gnt_block = 5;
      send_packet(1'b0, 5'd9, 3'b011, 6'd5, 6'd9, 6'd0);
      for (int c = 0; c < 5; c++) begin
         `CHK("held_req", {rfRdReq_o, rfRdWarp_o, rfRdReg_o}, {1'b1, 5'd9, 6'd5});
         @(negedge clk);
      end
      expect_dispatch(8);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         `CHK("held_valid", {opcolValid_o, stall_o}, 2'b11);
         `CHK("held_packet", opcolPacket_o, cur_pkt);
         chk_slot("held_operand1", opcolOperand_o[LW +: LW], exp_slot(1));
      end
      exReady_i = 1'b1;
      #1;
      `CHK("stall_in_hs", stall_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      exReady_i = 1'b0;
      `CHK("stall_after_hs", stall_o, 1'b0);

      // Flush after one grant of three with the response still pending.
      rsp_hold  = 1'b1;
      gnt_allow = 1;
      vld0      = vld_cnt;
      send_packet(1'b1, 5'd13, 3'b111, 6'd8, 6'd9, 6'd10);
      @(negedge clk);
      flush_i     = 1'b1;
      flushWarp_i = 5'd14;
      @(negedge clk);
      `CHK("other_warp_flush", dbg_state, 2'd1);
      flushWarp_i = 5'd13;
      @(negedge clk);
      flush_i = 1'b0;
      `CHK("drain_entered", dbg_state, 2'd3);
      rsp_hold = 1'b0;
      i = 0;
      while (dbg_state != 2'd0 && i < 10) begin
         @(negedge clk);
         i++;
      end
      `CHK("drain_done", dbg_state, 2'd0);
      `CHK("drain_absorbed", pend_q.size(), 0);
      `CHK("drain_no_valid", vld_cnt, vld0);
      gnt_allow = -1;

      // Flush coincident with exReady in DISPATCH drops the packet.
      send_packet(1'b0, 5'd21, 3'b101, 6'd40, 6'd41, 6'd42);
      expect_dispatch(3);
      hs0         = hs_cnt;
      flush_i     = 1'b1;
      flushWarp_i = 5'd21;
      exReady_i   = 1'b1;
      #1;
      `CHK("flush_valid_low", opcolValid_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      flush_i   = 1'b0;
      exReady_i = 1'b0;
      `CHK("flush_to_idle", dbg_state, 2'd0);
      `CHK("flush_no_hs", hs_cnt, hs0);

      // Flush in IDLE matching the incoming warp: packet not accepted.
      issuedWarp_i        = 5'd7;
      srcReg_i            = 21'h1;
      issuedPacketValid_i = 1'b1;
      flush_i             = 1'b1;
      flushWarp_i         = 5'd7;
      @(posedge clk);
      @(negedge clk);
      issuedPacketValid_i = 1'b0;
      flush_i             = 1'b0;
      `CHK("idle_flush_state", dbg_state, 2'd0);
      `CHK("idle_flush_stall", stall_o, 1'b0);

      // Reset mid-READ with two responses outstanding.
      rsp_hold  = 1'b1;
      gnt_allow = 2;
      send_packet(1'b1, 5'd17, 3'b111, 6'd11, 6'd12, 6'd13);
      i = 0;
      while (gnt_log.size() < 2 && i < 20) begin
         @(negedge clk);
         i++;
      end
      `CHK("two_granted", gnt_log.size(), 2);
      reset = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b1;
      rsp_hold  = 1'b0;
      gnt_allow = -1;
      repeat (4) @(negedge clk);
      `CHK("late_rsp_gone", pend_q.size(), 0);
      send_packet(1'b0, 5'd3, 3'b111, 6'd11, 6'd12, 6'd13);
      expect_dispatch(4);
      handshake(0);

      // Random packets with a randomly stalling RF and execute.
      gnt_rand = 1'b1;
      rsp_rand = 1'b1;
      for (int n = 0; n < 30; n++) begin
         send_packet(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)),
                     6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0)));
         expect_dispatch(-1);
         handshake($urandom_range(3, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
